operand_sequencer: RTL and testbench

Upstream feeder for the selector-driven routing stage (inputs `a`, `b`, `c`, `s`; outputs `w`, `v`, `y`, `t`). It buffers incoming operand triplets in a small FIFO. For each triplet it sweeps the selector `s` through a fixed range, one value per accepted beat, holding `a`, `b` and `c` stable. Its registered outputs drive the routing stage's `a`, `b`, `c` and `s` inputs directly.

---
 rtl/opseq_pkg.sv | 20 ++
 rtl/opseq_fifo.sv | 55 +++++
 rtl/operand_sequencer.sv | 100 ++++++++++
 tb/tb_operand_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/opseq_pkg.sv
// Shared types and constants for the operand sequencer.
// The sweep end point is selected by OPSEQ_FULL_SWEEP_EN in operand_sequencer.
package opseq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } opseq_state_e;

    localparam int OPSEQ_S_LAST_DEFAULT = 7;
    localparam int OPSEQ_WIDTH_DEFAULT  = 4;

    // Operand triplet view at the default operand width
    typedef struct packed {
        logic [OPSEQ_WIDTH_DEFAULT-1:0] a;
        logic [OPSEQ_WIDTH_DEFAULT-1:0] b;
        logic [OPSEQ_WIDTH_DEFAULT-1:0] c;
    } opseq_triplet_t;

endpackage

// File: rtl/opseq_fifo.sv
// Synchronous FIFO holding packed operand triplets; power-of-two DEPTH.
// Head entry is readable combinationally on dout.
module opseq_fifo #(
    parameter int DW    = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/operand_sequencer.sv
// Buffers operand triplets and sweeps the selector 0..S_LAST per triplet.
// Define OPSEQ_FULL_SWEEP_EN to sweep the full WIDTH-bit selector range.
module operand_sequencer
    import opseq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [WIDTH-1:0]         in_c,
    output logic [WIDTH-1:0]         out_a,
    output logic [WIDTH-1:0]         out_b,
    output logic [WIDTH-1:0]         out_c,
    output logic [WIDTH-1:0]         out_s,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   fifo_level
);

`ifdef OPSEQ_FULL_SWEEP_EN
    localparam logic [WIDTH-1:0] S_LAST = {WIDTH{1'b1}};
`else
    localparam logic [WIDTH-1:0] S_LAST = WIDTH'(OPSEQ_S_LAST_DEFAULT);
`endif

    opseq_state_e       state;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               hs;
    logic               at_last;
    logic [3*WIDTH-1:0] head;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign hs       = out_valid && out_ready;
    assign at_last  = (out_s == S_LAST);
    assign out_last = out_valid && at_last;
    // Pop on idle start or on the final beat so consecutive sweeps have no bubble
    assign pop      = !empty && ((state == IDLE) || (hs && at_last));

    opseq_fifo #(
        .DW    (3*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({in_a, in_b, in_c}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
            out_s     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        {out_a, out_b, out_c} <= head;
                        out_s     <= '0;
                        out_valid <= 1'b1;
                        state     <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (hs) begin
                        if (!at_last) begin
                            out_s <= out_s + WIDTH'(1);
                        end else if (!empty) begin
                            {out_a, out_b, out_c} <= head;
                            out_s <= '0;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with a beat-queue reference model.
// Honours OPSEQ_FULL_SWEEP_EN for the expected sweep length.
module tb_operand_sequencer;

    localparam int W     = 4;
    localparam int DEPTH = 4;
`ifdef OPSEQ_FULL_SWEEP_EN
    localparam int S_LAST = (1 << W) - 1;
`else
    localparam int S_LAST = 7;
`endif
    localparam int N = S_LAST + 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [W-1:0]           in_a, in_b, in_c;
    logic [W-1:0]           out_a, out_b, out_c, out_s;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic [$clog2(DEPTH):0] fifo_level;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int a;
        int b;
        int c;
        int s;
    } beat_t;

    beat_t exp_q[$];
    beat_t f;
    int    lvl;
    bit    last_push = 1'b0;

    always #5 clk = ~clk;

    operand_sequencer #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_c      (out_c),
        .out_s      (out_s),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .fifo_level (fifo_level)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: every accepted triplet expands into N expected beats
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            last_push = 1'b0;
            chk("rst_valid", int'(out_valid), 0);
            chk("rst_level", int'(fifo_level), 0);
            chk("rst_s", int'(out_s), 0);
        end else begin
            lvl = exp_q.size() / N;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                    lvl = 0;
                end else begin
                    f = exp_q[0];
                    chk("m_a", int'(out_a), f.a);
                    chk("m_b", int'(out_b), f.b);
                    chk("m_c", int'(out_c), f.c);
                    chk("m_s", int'(out_s), f.s);
                    chk("m_last", int'(out_last), int'(f.s == S_LAST));
                    lvl = (exp_q.size() - (N - f.s)) / N;
                end
            end else begin
                chk("m_last_idle", int'(out_last), 0);
                // Only a triplet pushed on the previous edge may still be waiting
                if (exp_q.size() > (last_push ? N : 0))
                    chk("m_bubble", int'(out_valid), 1);
            end
            chk("m_level", int'(fifo_level), lvl);
            chk("m_in_ready", int'(in_ready), int'(lvl != DEPTH));
            if (out_valid && out_ready && exp_q.size() > 0)
                void'(exp_q.pop_front());
            last_push = in_valid && in_ready;
            if (last_push)
                for (int s = 0; s < N; s++)
                    exp_q.push_back('{int'(in_a), int'(in_b), int'(in_c), s});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        // Reset with in_valid held high
        rst = 1'b1; in_valid = 1'b1; in_a = 4'd5; in_b = 4'd6; in_c = 4'd7; out_ready = 1'b1;
        repeat (3) tick();
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_last", int'(out_last), 0);
        chk("reset_a", int'(out_a), 0);
        chk("reset_s", int'(out_s), 0);
        chk("reset_level", int'(fifo_level), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("post_reset_level", int'(fifo_level), 0);

        // Single triplet sweep
        in_a = 4'd1; in_b = 4'd2; in_c = 4'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_k", int'(out_valid), 0);
        tick();
        chk("lat_k1", int'(out_valid), 1);
        for (int i = 0; i < N; i++) begin
            chk("one_s", int'(out_s), i);
            chk("one_a", int'(out_a), 1);
            chk("one_b", int'(out_b), 2);
            chk("one_c", int'(out_c), 3);
            chk("one_last", int'(out_last), int'(i == N - 1));
            tick();
        end
        chk("one_idle", int'(out_valid), 0);

        // Two triplets back-to-back, no bubble
        in_a = 4'd4; in_b = 4'd5; in_c = 4'd6; in_valid = 1'b1;
        tick();
        in_a = 4'd7; in_b = 4'd8; in_c = 4'd9;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            chk("two_valid", int'(out_valid), 1);
            chk("two_s", int'(out_s), i % N);
            chk("two_a", int'(out_a), (i < N) ? 4 : 7);
            chk("two_c", int'(out_c), (i < N) ? 6 : 9);
            tick();
        end
        chk("two_idle", int'(out_valid), 0);

        // Backpressure: one triplet in flight plus four stored
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            in_a = 4'(j + 1); in_b = 4'(j + 2); in_c = 4'(j + 3); in_valid = 1'b1;
            chk("fill_ready", int'(in_ready), 1);
            tick();
        end
        in_a = 4'd15; in_b = 4'd14; in_c = 4'd13;
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_level", int'(fifo_level), 4);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("frozen_s", int'(out_s), 0);
            chk("frozen_a", int'(out_a), 1);
            chk("frozen_valid", int'(out_valid), 1);
            chk("frozen_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("sixth_accept", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        cnt = 0;
        while ((out_valid || fifo_level != 0) && cnt < 300) begin
            tick();
            cnt++;
        end
        chk("drain_done", int'(out_valid || fifo_level != 0), 0);

        // Asynchronous reset mid-sweep
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_a = 4'(10 + j); in_b = 4'(2 * j); in_c = 4'(j); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        chk("pre_rst_s", int'(out_s), 3);
        chk("pre_rst_level", int'(fifo_level), 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_s", int'(out_s), 0);
        chk("arst_a", int'(out_a), 0);
        chk("arst_level", int'(fifo_level), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("post_arst_valid", int'(out_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
